// File: rtl/moldudp64_pkg.sv
// Shared widths, end-of-session marker and session table entry for the
// MoldUDP64 sequence tracker.
package moldudp64_pkg;

    localparam int unsigned SID_W     = 80;
    localparam int unsigned SEQ_NUM_W = 64;
    localparam int unsigned ML_W      = 16;

    localparam logic [ML_W-1:0] EOS_MSG_CNT = {ML_W{1'b1}};

    typedef struct packed {
        logic                 valid;
        logic [SID_W-1:0]     sid;
        logic [SEQ_NUM_W-1:0] next_seq;
        logic                 eos;
    } sess_entry_t;

    // End of a header's message range, modulo 2^SEQ_NUM_W
    function automatic logic [SEQ_NUM_W-1:0] seq_add(
        input logic [SEQ_NUM_W-1:0] seq,
        input logic [ML_W-1:0]      cnt
    );
        return seq + SEQ_NUM_W'(cnt);
    endfunction

endpackage

// File: rtl/moldudp64_hb_timer.sv
// Per-session heartbeat timer: saturating idle counter with clear and
// enable; flatlined is high while the counter sits at TIMEOUT.
module moldudp64_hb_timer #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic nreset,
    input  logic clr,
    input  logic en,
    output logic flatlined
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt;

    // Count idle cycles; clear wins, disabled counters hold their value
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LIMIT)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign flatlined = (cnt == LIMIT);

endmodule

// File: rtl/moldudp64_seq_track.sv
// Multi-session MoldUDP64 sequence tracker: SID lookup, entry allocation
// with round-robin eviction, accept/trim/drop classification, gap and
// end-of-session reporting, per-session heartbeat loss.
module moldudp64_seq_track
    import moldudp64_pkg::*;
#(
    parameter  int unsigned SESS_N     = 4,
    parameter  int unsigned HB_CNT_W   = 32,
    parameter  int unsigned HB_TIMEOUT = 1000000,
    localparam int unsigned IDX_W      = (SESS_N > 1) ? $clog2(SESS_N) : 1
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 hdr_v_i,
    input  logic [SID_W-1:0]     hdr_sid_i,
    input  logic [SEQ_NUM_W-1:0] hdr_seq_num_i,
    input  logic [ML_W-1:0]      hdr_msg_cnt_i,
    output logic                 res_v_o,
    output logic [IDX_W-1:0]     res_sess_idx_o,
    output logic                 res_new_sess_o,
    output logic                 res_drop_o,
    output logic [ML_W-1:0]      res_skip_cnt_o,
    output logic                 miss_v_o,
    output logic [SEQ_NUM_W-1:0] miss_seq_num_start_o,
    output logic [SEQ_NUM_W-1:0] miss_seq_num_cnt_o,
    output logic                 eos_v_o,
    output logic [SESS_N-1:0]    flatlined_v_o
);

    sess_entry_t          tbl [SESS_N];
    logic [IDX_W-1:0]     victim;

    logic [SESS_N-1:0]    hit_vec;
    logic                 hit;
    logic [IDX_W-1:0]     hit_idx;
    logic                 have_free;
    logic [IDX_W-1:0]     free_idx;
    logic [SEQ_NUM_W-1:0] cur_next;
    logic                 cur_eos;

    logic                 is_eos;
    logic                 gap;
    logic [SEQ_NUM_W-1:0] seq_end;
    logic                 alloc;
    logic                 evict;
    logic                 wr_en;
    logic [IDX_W-1:0]     wr_idx;
    sess_entry_t          wr_entry;
    logic [SESS_N-1:0]    touch;

    logic                 n_new;
    logic                 n_drop;
    logic [IDX_W-1:0]     n_idx;
    logic [ML_W-1:0]      n_skip;
    logic                 n_miss;
    logic [SEQ_NUM_W-1:0] n_miss_start;
    logic [SEQ_NUM_W-1:0] n_miss_cnt;
    logic                 n_eos;

    // SID CAM compare and lowest-free-entry priority encoder
    always_comb begin
        hit_vec   = '0;
        hit       = 1'b0;
        hit_idx   = '0;
        have_free = 1'b0;
        free_idx  = '0;
        cur_next  = '0;
        cur_eos   = 1'b0;
        for (int unsigned i = 0; i < SESS_N; i++) begin
            hit_vec[i] = tbl[i].valid && (tbl[i].sid == hdr_sid_i);
            if (hit_vec[i]) begin
                hit      = 1'b1;
                hit_idx  = IDX_W'(i);
                cur_next = tbl[i].next_seq;
                cur_eos  = tbl[i].eos;
            end
            if (!tbl[i].valid && !have_free) begin
                have_free = 1'b1;
                free_idx  = IDX_W'(i);
            end
        end
    end

    // Sequence classifier: result fields and the table write for this header
    always_comb begin
        is_eos       = (hdr_msg_cnt_i == EOS_MSG_CNT);
        seq_end      = seq_add(hdr_seq_num_i, hdr_msg_cnt_i);
        gap          = (hdr_seq_num_i > cur_next);
        alloc        = !hit && !is_eos;
        evict        = alloc && !have_free;
        wr_en        = 1'b0;
        wr_idx       = hit ? hit_idx : (have_free ? free_idx : victim);
        wr_entry     = '{valid: 1'b1, sid: hdr_sid_i, next_seq: cur_next, eos: cur_eos};
        n_new        = 1'b0;
        n_drop       = 1'b0;
        n_idx        = '0;
        n_skip       = '0;
        n_miss       = 1'b0;
        n_miss_start = '0;
        n_miss_cnt   = '0;
        n_eos        = 1'b0;
        if (!hit) begin
            if (is_eos) begin
                n_drop = 1'b1;
                n_eos  = 1'b1;
            end else begin
                wr_en             = 1'b1;
                wr_entry.next_seq = seq_end;
                wr_entry.eos      = 1'b0;
                n_new             = 1'b1;
                n_idx             = wr_idx;
                n_drop            = (hdr_msg_cnt_i == '0);
            end
        end else begin
            n_idx = hit_idx;
            if (cur_eos) begin
                n_drop = 1'b1;
            end else begin
                wr_en = 1'b1;
                if (gap) begin
                    n_miss       = 1'b1;
                    n_miss_start = cur_next;
                    n_miss_cnt   = hdr_seq_num_i - cur_next;
                end
                if (is_eos) begin
                    wr_entry.eos = 1'b1;
                    n_eos        = 1'b1;
                    n_drop       = 1'b1;
                end else if (hdr_msg_cnt_i == '0) begin
                    n_drop = 1'b1;
                    if (gap) begin
                        wr_entry.next_seq = hdr_seq_num_i;
                    end
                end else if (hdr_seq_num_i >= cur_next) begin
                    wr_entry.next_seq = seq_end;
                end else if (seq_end <= cur_next) begin
                    n_drop = 1'b1;
                    n_skip = hdr_msg_cnt_i;
                end else begin
                    // Partial overlap: E - seq < cnt, so the truncation is exact
                    n_skip            = ML_W'(cur_next - hdr_seq_num_i);
                    wr_entry.next_seq = seq_end;
                end
            end
        end
    end

    // Entries touched by this header get their heartbeat restarted
    always_comb begin
        touch = '0;
        for (int unsigned i = 0; i < SESS_N; i++) begin
            touch[i] = hdr_v_i && (hit_vec[i] || (alloc && (wr_idx == IDX_W'(i))));
        end
    end

    // Registered single-cycle results, table update and victim rotation
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int unsigned i = 0; i < SESS_N; i++) begin
                tbl[i] <= '0;
            end
            victim               <= '0;
            res_v_o              <= 1'b0;
            res_sess_idx_o       <= '0;
            res_new_sess_o       <= 1'b0;
            res_drop_o           <= 1'b0;
            res_skip_cnt_o       <= '0;
            miss_v_o             <= 1'b0;
            miss_seq_num_start_o <= '0;
            miss_seq_num_cnt_o   <= '0;
            eos_v_o              <= 1'b0;
        end else begin
            res_v_o              <= hdr_v_i;
            res_sess_idx_o       <= hdr_v_i ? n_idx : '0;
            res_new_sess_o       <= hdr_v_i && n_new;
            res_drop_o           <= hdr_v_i && n_drop;
            res_skip_cnt_o       <= hdr_v_i ? n_skip : '0;
            miss_v_o             <= hdr_v_i && n_miss;
            miss_seq_num_start_o <= hdr_v_i ? n_miss_start : '0;
            miss_seq_num_cnt_o   <= hdr_v_i ? n_miss_cnt : '0;
            eos_v_o              <= hdr_v_i && n_eos;
            if (hdr_v_i && wr_en) begin
                tbl[wr_idx] <= wr_entry;
            end
            if (hdr_v_i && evict) begin
                victim <= (victim == IDX_W'(SESS_N - 1)) ? '0 : victim + IDX_W'(1);
            end
        end
    end

    for (genvar g = 0; g < SESS_N; g++) begin : g_hb
        moldudp64_hb_timer #(
            .CNT_W   (HB_CNT_W),
            .TIMEOUT (HB_TIMEOUT)
        ) u_hb (
            .clk       (clk),
            .nreset    (nreset),
            .clr       (touch[g]),
            .en        (tbl[g].valid && !tbl[g].eos),
            .flatlined (flatlined_v_o[g])
        );
    end

endmodule

// File: tb/tb_moldudp64_seq_track.sv
// Self-checking bench for moldudp64_seq_track: directed scenarios plus
// randomized headers compared against a behavioural session model.
module tb_moldudp64_seq_track;
    import moldudp64_pkg::*;

    localparam int unsigned SESS_N     = 2;
    localparam int unsigned HB_TIMEOUT = 8;
    localparam int unsigned IDX_W      = 1;

    logic                 clk = 1'b0;
    logic                 nreset;
    logic                 hdr_v_i;
    logic [SID_W-1:0]     hdr_sid_i;
    logic [SEQ_NUM_W-1:0] hdr_seq_num_i;
    logic [ML_W-1:0]      hdr_msg_cnt_i;
    logic                 res_v_o;
    logic [IDX_W-1:0]     res_sess_idx_o;
    logic                 res_new_sess_o;
    logic                 res_drop_o;
    logic [ML_W-1:0]      res_skip_cnt_o;
    logic                 miss_v_o;
    logic [SEQ_NUM_W-1:0] miss_seq_num_start_o;
    logic [SEQ_NUM_W-1:0] miss_seq_num_cnt_o;
    logic                 eos_v_o;
    logic [SESS_N-1:0]    flatlined_v_o;

    always #5 clk = ~clk;

    moldudp64_seq_track #(
        .SESS_N     (SESS_N),
        .HB_CNT_W   (32),
        .HB_TIMEOUT (HB_TIMEOUT)
    ) dut (
        .clk                  (clk),
        .nreset               (nreset),
        .hdr_v_i              (hdr_v_i),
        .hdr_sid_i            (hdr_sid_i),
        .hdr_seq_num_i        (hdr_seq_num_i),
        .hdr_msg_cnt_i        (hdr_msg_cnt_i),
        .res_v_o              (res_v_o),
        .res_sess_idx_o       (res_sess_idx_o),
        .res_new_sess_o       (res_new_sess_o),
        .res_drop_o           (res_drop_o),
        .res_skip_cnt_o       (res_skip_cnt_o),
        .miss_v_o             (miss_v_o),
        .miss_seq_num_start_o (miss_seq_num_start_o),
        .miss_seq_num_cnt_o   (miss_seq_num_cnt_o),
        .eos_v_o              (eos_v_o),
        .flatlined_v_o        (flatlined_v_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: session list plus idle age per session
    logic                 m_valid [SESS_N];
    logic [SID_W-1:0]     m_sid   [SESS_N];
    logic [SEQ_NUM_W-1:0] m_next  [SESS_N];
    logic                 m_eos   [SESS_N];
    int unsigned          m_idle  [SESS_N];
    logic                 m_touch [SESS_N];
    int unsigned          m_victim;

    logic                 e_v, e_new, e_drop, e_miss, e_eos;
    int unsigned          e_idx;
    logic [ML_W-1:0]      e_skip;
    logic [SEQ_NUM_W-1:0] e_mstart, e_mcnt;

    task automatic model_reset();
        for (int i = 0; i < SESS_N; i++) begin
            m_valid[i] = 1'b0; m_sid[i] = '0; m_next[i] = '0;
            m_eos[i] = 1'b0; m_idle[i] = 0; m_touch[i] = 1'b0;
        end
        m_victim = 0;
    endtask

    task automatic model_clear_exp();
        e_v = 0; e_new = 0; e_drop = 0; e_miss = 0; e_eos = 0;
        e_idx = 0; e_skip = '0; e_mstart = '0; e_mcnt = '0;
    endtask

    task automatic model_hdr(input logic [SID_W-1:0] sid, input logic [SEQ_NUM_W-1:0] seq,
                             input logic [ML_W-1:0] cnt);
        int h;
        int slot;
        logic [SEQ_NUM_W-1:0] e;
        logic [SEQ_NUM_W-1:0] hi;
        model_clear_exp();
        e_v  = 1;
        h    = -1;
        slot = -1;
        hi   = seq + {48'd0, cnt};
        for (int i = 0; i < SESS_N; i++) if (m_valid[i] && m_sid[i] == sid) h = i;
        if (h < 0) begin
            if (cnt == 16'hffff) begin
                e_drop = 1; e_eos = 1;
            end else begin
                for (int i = SESS_N - 1; i >= 0; i--) if (!m_valid[i]) slot = i;
                if (slot < 0) begin
                    slot     = int'(m_victim);
                    m_victim = (m_victim + 1) % SESS_N;
                end
                m_valid[slot] = 1; m_sid[slot] = sid; m_next[slot] = hi;
                m_eos[slot] = 0; m_touch[slot] = 1;
                e_new = 1; e_idx = slot; e_drop = (cnt == 0);
            end
        end else begin
            e_idx = h;
            m_touch[h] = 1;
            e = m_next[h];
            if (m_eos[h]) begin
                e_drop = 1;
            end else begin
                if (seq > e) begin
                    e_miss = 1; e_mstart = e; e_mcnt = seq - e;
                end
                if (cnt == 16'hffff) begin
                    m_eos[h] = 1; e_eos = 1; e_drop = 1;
                end else if (cnt == 0) begin
                    e_drop = 1;
                    if (seq > e) m_next[h] = seq;
                end else if (seq >= e) begin
                    m_next[h] = hi;
                end else if (hi <= e) begin
                    e_drop = 1; e_skip = cnt;
                end else begin
                    e_skip = 16'(e - seq); m_next[h] = hi;
                end
            end
        end
    endtask

    task automatic model_tick();
        for (int i = 0; i < SESS_N; i++) begin
            if (m_touch[i]) m_idle[i] = 0;
            else if (m_idle[i] < HB_TIMEOUT) m_idle[i]++;
            m_touch[i] = 0;
        end
    endtask

    function automatic logic [SESS_N-1:0] exp_flat();
        logic [SESS_N-1:0] f;
        for (int i = 0; i < SESS_N; i++) f[i] = m_valid[i] && !m_eos[i] && (m_idle[i] >= HB_TIMEOUT);
        return f;
    endfunction

    task automatic check_outputs();
        check_eq("res_v",      res_v_o,              e_v);
        check_eq("sess_idx",   res_sess_idx_o,       e_idx);
        check_eq("new_sess",   res_new_sess_o,       e_new);
        check_eq("drop",       res_drop_o,           e_drop);
        check_eq("skip",       res_skip_cnt_o,       e_skip);
        check_eq("miss_v",     miss_v_o,             e_miss);
        check_eq("miss_start", miss_seq_num_start_o, e_mstart);
        check_eq("miss_cnt",   miss_seq_num_cnt_o,   e_mcnt);
        check_eq("eos_v",      eos_v_o,              e_eos);
        check_eq("flatlined",  flatlined_v_o,        exp_flat());
    endtask

    // One clock: drive a header (or idle), then check the result after the edge
    task automatic step(input logic v, input logic [SID_W-1:0] sid,
                        input logic [SEQ_NUM_W-1:0] seq, input logic [ML_W-1:0] cnt);
        hdr_v_i = v; hdr_sid_i = sid; hdr_seq_num_i = seq; hdr_msg_cnt_i = cnt;
        if (v) model_hdr(sid, seq, cnt);
        else   model_clear_exp();
        @(posedge clk);
        #1;
        model_tick();
        check_outputs();
        hdr_v_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, '0, '0);
    endtask

    logic [SID_W-1:0] sid_a, sid_b, sid_c, sid_d, sid_e;
    logic [SID_W-1:0] pool [4];

    initial begin
        sid_a = {48'hA0A0_A0A0_A0A0, 32'd1};
        sid_b = {48'hB0B0_B0B0_B0B0, 32'd2};
        sid_c = {48'hC0C0_C0C0_C0C0, 32'd3};
        sid_d = {48'hD0D0_D0D0_D0D0, 32'd4};
        sid_e = {48'hE0E0_E0E0_E0E0, 32'd5};

        nreset = 1'b0;
        hdr_v_i = 1'b0; hdr_sid_i = '0; hdr_seq_num_i = '0; hdr_msg_cnt_i = '0;
        model_reset();
        model_clear_exp();
        @(posedge clk); @(posedge clk); #1;
        check_outputs();
        #2 nreset = 1'b1;

        // Single session walk-through
        step(1, sid_a, 64'd10, 16'd3);
        check_eq("dir_new_a", {res_new_sess_o, res_sess_idx_o, res_skip_cnt_o}, {1'b1, 1'b0, 16'd0});
        step(1, sid_a, 64'd13, 16'd2);
        check_eq("dir_accept", {res_drop_o, miss_v_o}, 2'b00);
        step(1, sid_a, 64'd20, 16'd1);
        check_eq("dir_gap", {miss_v_o, miss_seq_num_start_o, miss_seq_num_cnt_o}, {1'b1, 64'd15, 64'd5});
        step(1, sid_a, 64'd19, 16'd4);
        check_eq("dir_trim", {res_drop_o, res_skip_cnt_o}, {1'b0, 16'd2});
        step(1, sid_a, 64'd19, 16'd2);
        check_eq("dir_dup", {res_drop_o, res_skip_cnt_o}, {1'b1, 16'd2});
        step(1, sid_a, 64'd23, 16'hffff);
        check_eq("dir_eos", {eos_v_o, res_drop_o}, 2'b11);
        step(1, sid_a, 64'd30, 16'd1);
        check_eq("dir_after_eos", {res_drop_o, miss_v_o, eos_v_o}, 3'b100);
        idle(HB_TIMEOUT + 2);
        check_eq("dir_eos_no_flat", flatlined_v_o[0], 1'b0);

        // Allocation and round-robin eviction
        step(1, sid_b, 64'd100, 16'd1);
        check_eq("evict_b_idx", {res_new_sess_o, res_sess_idx_o}, 2'b11);
        step(1, sid_c, 64'd200, 16'd1);
        check_eq("evict_c_idx", {res_new_sess_o, res_sess_idx_o}, 2'b10);
        step(1, sid_d, 64'd300, 16'd0);
        check_eq("evict_d_idx", {res_new_sess_o, res_sess_idx_o, res_drop_o}, 3'b111);
        step(1, sid_e, 64'd400, 16'd2);
        check_eq("evict_wrap", {res_new_sess_o, res_sess_idx_o}, 2'b10);

        // Heartbeat loss on an idle session
        nreset = 1'b0; #1; nreset = 1'b1;
        model_reset();
        step(1, sid_a, 64'd1, 16'd1);
        step(1, sid_b, 64'd50, 16'd1);
        idle(HB_TIMEOUT - 1);
        check_eq("hb_before", flatlined_v_o[1], 1'b0);
        idle(1);
        check_eq("hb_rise", flatlined_v_o[1], 1'b1);
        step(1, sid_b, 64'd51, 16'd1);
        check_eq("hb_clear", flatlined_v_o[1], 1'b0);

        // Randomized traffic
        pool[0] = sid_a; pool[1] = sid_b; pool[2] = sid_c; pool[3] = sid_d;
        for (int n = 0; n < 1500; n++) begin
            int unsigned r;
            int unsigned pick;
            int off;
            int h;
            logic [SEQ_NUM_W-1:0] base;
            logic [ML_W-1:0] cnt;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                idle(int'($urandom_range(5, 12)));
            end else if (r < 4) begin
                idle(1);
            end else begin
                pick = $urandom_range(0, 3);
                h = -1;
                for (int i = 0; i < SESS_N; i++) if (m_valid[i] && m_sid[i] == pool[pick]) h = i;
                if (h >= 0) base = m_next[h];
                else if ($urandom_range(0, 3) == 0) base = 64'hFFFF_FFFF_FFFF_FFFC;
                else base = {32'd0, $urandom};
                off = int'($urandom_range(0, 10)) - 5;
                r = $urandom_range(0, 19);
                if (r == 0) cnt = 16'd0;
                else if (r == 1) cnt = 16'hffff;
                else cnt = 16'($urandom_range(1, 6));
                step(1, pool[pick], base + 64'(off), cnt);
            end
        end

        // Asynchronous reset in the middle of a header
        hdr_v_i = 1'b1; hdr_sid_i = sid_c; hdr_seq_num_i = 64'd7; hdr_msg_cnt_i = 16'd1;
        #3 nreset = 1'b0;
        #1;
        model_reset();
        model_clear_exp();
        check_outputs();
        @(posedge clk); #1;
        check_outputs();
        hdr_v_i = 1'b0;
        #2 nreset = 1'b1;
        step(1, sid_c, 64'd7, 16'd1);
        check_eq("post_rst_new", {res_new_sess_o, res_sess_idx_o}, 2'b10);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
